// File: rtl/execute_mc.sv
// execute_mc -- execute stage with single-cycle ALU ops plus iterative
// unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
//
// Ports
//   clock, reset        : single clock, synchronous active-high reset
//   in_valid / in_ready : operation handshake; ready only while idle
//   op                  : 0 ADD 1 SUB 2 AND 3 OR 4 SLT 5 SLTU 6 LUI 7 LINK
//                         8 MULTU 9 DIVU 10 MFHI 11 MFLO, 12-15 reserved
//   register_rs/rt      : A and B register operands
//   sign_extend         : extended immediate (B when alusrc=1)
//   alusrc, branch, regdst, link : operand / branch / destination selects
//   pc4                 : PC+4 of the operation
//   wreg_rd, wreg_rt    : candidate destination registers
//   out_valid           : one-cycle result pulse, no backpressure
//   alu_result, branch_addr, do_branch, reg_write, wreg_address : results
//
// State table
//   ST_IDLE | accepting operations, single-cycle ops complete from here
//   ST_MUL  | MULTU shift-add iterations, inputs ignored
//   ST_DIV  | DIVU restoring iterations, inputs ignored
module execute_mc #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] register_rs,
    input  logic [WIDTH-1:0] register_rt,
    input  logic [WIDTH-1:0] sign_extend,
    input  logic             alusrc,
    input  logic             branch,
    input  logic             regdst,
    input  logic             link,
    input  logic [WIDTH-1:0] pc4,
    input  logic [4:0]       wreg_rd,
    input  logic [4:0]       wreg_rt,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] branch_addr,
    output logic             do_branch,
    output logic             reg_write,
    output logic [4:0]       wreg_address
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_SLT   = 4'd4;
    localparam logic [3:0] OP_SLTU  = 4'd5;
    localparam logic [3:0] OP_LUI   = 4'd6;
    localparam logic [3:0] OP_LINK  = 4'd7;
    localparam logic [3:0] OP_MULTU = 4'd8;
    localparam logic [3:0] OP_DIVU  = 4'd9;
    localparam logic [3:0] OP_MFHI  = 4'd10;
    localparam logic [3:0] OP_MFLO  = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      iter_cnt;
    logic [WIDTH-1:0]   hi;
    logic [WIDTH-1:0]   lo;
    // Multiplicand (MUL) or divisor (DIV), held for the whole operation.
    logic [WIDTH-1:0]   opnd;
    // MUL: {partial product high, remaining multiplier bits / product low}
    // DIV: {partial remainder, dividend bits shifting into quotient}
    logic [2*WIDTH-1:0] acc;

    logic [WIDTH-1:0]   operand_b;
    logic [WIDTH-1:0]   sc_result;
    logic               sc_reg_write;
    logic               sc_do_branch;
    logic [WIDTH-1:0]   branch_target;
    logic [4:0]         dest_reg;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_shift;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;

    assign in_ready = (state == ST_IDLE);

    always_comb begin
        operand_b     = alusrc ? sign_extend : register_rt;
        branch_target = pc4 + (sign_extend << 2);
        dest_reg      = link ? 5'd31 : (regdst ? wreg_rd : wreg_rt);

        sc_result = '0;
        case (op)
            OP_ADD:  sc_result = register_rs + operand_b;
            OP_SUB:  sc_result = register_rs - operand_b;
            OP_AND:  sc_result = register_rs & operand_b;
            OP_OR:   sc_result = register_rs | operand_b;
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}},
                                  ($signed(register_rs) < $signed(operand_b))};
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (register_rs < operand_b)};
            OP_LUI:  sc_result = {operand_b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            OP_LINK: sc_result = pc4;
            OP_MFHI: sc_result = hi;
            OP_MFLO: sc_result = lo;
            default: sc_result = '0;
        endcase

        sc_reg_write = (op <= OP_LINK) || (op == OP_MFHI) || (op == OP_MFLO);
        sc_do_branch = (op == OP_SUB) && branch && (sc_result == '0);

        // One shift-add step: conditionally add multiplicand into the high
        // half, then shift the whole accumulator right (carry enters at top).
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
        mul_next = {mul_sum, acc[WIDTH-1:1]};

        // One restoring step: shift the next dividend bit into the remainder
        // and keep the subtraction only when it does not go negative.
        rem_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_trial = rem_shift - {1'b0, opnd};
        if (div_trial[WIDTH])
            div_next = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            div_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= ST_IDLE;
            iter_cnt     <= '0;
            hi           <= '0;
            lo           <= '0;
            opnd         <= '0;
            acc          <= '0;
            out_valid    <= 1'b0;
            alu_result   <= '0;
            branch_addr  <= '0;
            do_branch    <= 1'b0;
            reg_write    <= 1'b0;
            wreg_address <= '0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        iter_cnt     <= '0;
                        branch_addr  <= branch_target;
                        wreg_address <= dest_reg;
                        case (op)
                            OP_MULTU: begin
                                state     <= ST_MUL;
                                opnd      <= register_rs;
                                acc       <= {{WIDTH{1'b0}}, operand_b};
                                reg_write <= 1'b0;
                                do_branch <= 1'b0;
                            end
                            OP_DIVU: begin
                                reg_write <= 1'b0;
                                do_branch <= 1'b0;
                                if (operand_b == '0) begin
                                    // Divide by zero finishes immediately.
                                    out_valid  <= 1'b1;
                                    alu_result <= '1;
                                    lo         <= '1;
                                    hi         <= register_rs;
                                end else begin
                                    state <= ST_DIV;
                                    opnd  <= operand_b;
                                    acc   <= {{WIDTH{1'b0}}, register_rs};
                                end
                            end
                            default: begin
                                out_valid  <= 1'b1;
                                alu_result <= sc_result;
                                reg_write  <= sc_reg_write;
                                do_branch  <= sc_do_branch;
                            end
                        endcase
                    end
                end
                ST_MUL: begin
                    acc <= mul_next;
                    if (iter_cnt == LAST_ITER) begin
                        state      <= ST_IDLE;
                        hi         <= mul_next[2*WIDTH-1:WIDTH];
                        lo         <= mul_next[WIDTH-1:0];
                        alu_result <= mul_next[WIDTH-1:0];
                        out_valid  <= 1'b1;
                    end else begin
                        iter_cnt <= iter_cnt + CW'(1);
                    end
                end
                ST_DIV: begin
                    acc <= div_next;
                    if (iter_cnt == LAST_ITER) begin
                        state      <= ST_IDLE;
                        hi         <= div_next[2*WIDTH-1:WIDTH];
                        lo         <= div_next[WIDTH-1:0];
                        alu_result <= div_next[WIDTH-1:0];
                        out_valid  <= 1'b1;
                    end else begin
                        iter_cnt <= iter_cnt + CW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_mc.sv
module tb_execute_mc;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    // 32-bit instance
    logic        reset, in_valid, in_ready;
    logic [3:0]  op;
    logic [31:0] register_rs, register_rt, sign_extend, pc4;
    logic        alusrc, branch, regdst, link;
    logic [4:0]  wreg_rd, wreg_rt;
    logic        out_valid, do_branch, reg_write;
    logic [31:0] alu_result, branch_addr;
    logic [4:0]  wreg_address;

    // 16-bit instance
    logic        h_reset, h_in_valid, h_in_ready;
    logic [3:0]  h_op;
    logic [15:0] h_rs, h_rt, h_se, h_pc4;
    logic        h_out_valid, h_do_branch, h_reg_write;
    logic [15:0] h_alu_result, h_branch_addr;
    logic [4:0]  h_wreg_address;

    execute_mc #(.WIDTH(32)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .register_rs(register_rs), .register_rt(register_rt),
        .sign_extend(sign_extend), .alusrc(alusrc), .branch(branch),
        .regdst(regdst), .link(link), .pc4(pc4), .wreg_rd(wreg_rd),
        .wreg_rt(wreg_rt), .out_valid(out_valid), .alu_result(alu_result),
        .branch_addr(branch_addr), .do_branch(do_branch), .reg_write(reg_write),
        .wreg_address(wreg_address)
    );

    execute_mc #(.WIDTH(16)) dut16 (
        .clock(clock), .reset(h_reset), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .op(h_op), .register_rs(h_rs), .register_rt(h_rt),
        .sign_extend(h_se), .alusrc(1'b0), .branch(1'b0),
        .regdst(1'b1), .link(1'b0), .pc4(h_pc4), .wreg_rd(5'd3),
        .wreg_rt(5'd4), .out_valid(h_out_valid), .alu_result(h_alu_result),
        .branch_addr(h_branch_addr), .do_branch(h_do_branch), .reg_write(h_reg_write),
        .wreg_address(h_wreg_address)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] m_hi, m_lo;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one operation and check its result against the reference model.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] rt,
                          input logic [31:0] se, input logic als, input logic br,
                          input logic rdst, input logic lk, input logic [31:0] pc,
                          input logic [4:0] rd, input logic [4:0] rtn);
        logic [31:0] b, exp_res, exp_ba;
        logic [63:0] prod;
        logic [4:0]  exp_wa;
        logic        exp_rw, exp_db, long_op;
        int          cyc, bad;
        @(negedge clock);
        check_val("in_ready_idle", {63'd0, in_ready}, 64'd1);
        op = o; register_rs = a; register_rt = rt; sign_extend = se; alusrc = als;
        branch = br; regdst = rdst; link = lk; pc4 = pc; wreg_rd = rd; wreg_rt = rtn;
        in_valid = 1'b1;

        b       = als ? se : rt;
        exp_ba  = pc + (se << 2);
        exp_wa  = lk ? 5'd31 : (rdst ? rd : rtn);
        long_op = 1'b0;
        case (o)
            4'd0:  exp_res = a + b;
            4'd1:  exp_res = a - b;
            4'd2:  exp_res = a & b;
            4'd3:  exp_res = a | b;
            4'd4:  exp_res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5:  exp_res = (a < b) ? 32'd1 : 32'd0;
            4'd6:  exp_res = {b[15:0], 16'h0000};
            4'd7:  exp_res = pc;
            4'd8: begin
                prod    = {32'd0, a} * {32'd0, b};
                m_hi    = prod[63:32];
                m_lo    = prod[31:0];
                exp_res = m_lo;
                long_op = 1'b1;
            end
            4'd9: begin
                if (b == 32'd0) begin
                    m_lo = 32'hFFFF_FFFF;
                    m_hi = a;
                end else begin
                    m_lo    = a / b;
                    m_hi    = a % b;
                    long_op = 1'b1;
                end
                exp_res = m_lo;
            end
            4'd10: exp_res = m_hi;
            4'd11: exp_res = m_lo;
            default: exp_res = 32'd0;
        endcase
        exp_rw = (o <= 4'd7) || (o == 4'd10) || (o == 4'd11);
        exp_db = (o == 4'd1) && br && (exp_res == 32'd0);

        @(posedge clock); #1;
        if (long_op) begin
            cyc = 1;
            bad = 0;
            while (!out_valid && cyc < 100) begin
                if (in_ready !== 1'b0) bad++;
                // garbage on the inputs must be ignored while busy
                in_valid = 1'b1;
                op = 4'($urandom_range(0, 15));
                register_rs = $urandom;
                @(posedge clock); #1;
                cyc++;
            end
            in_valid = 1'b0;
            check_val("long_latency", 64'(cyc), 64'd33);
            check_val("busy_ready_low", 64'(bad), 64'd0);
        end
        in_valid = 1'b0;
        check_val("out_valid", {63'd0, out_valid}, 64'd1);
        check_val("alu_result", {32'd0, alu_result}, {32'd0, exp_res});
        check_val("reg_write", {63'd0, reg_write}, {63'd0, exp_rw});
        check_val("do_branch", {63'd0, do_branch}, {63'd0, exp_db});
        check_val("branch_addr", {32'd0, branch_addr}, {32'd0, exp_ba});
        check_val("wreg_address", {59'd0, wreg_address}, {59'd0, exp_wa});
    endtask

    task automatic idle_cycle();
        @(negedge clock);
        in_valid = 1'b0;
        @(posedge clock); #1;
        check_val("idle_no_pulse", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        int pulses;
        logic [31:0] ra, rb;
        reset = 1'b1; in_valid = 1'b0; op = '0; register_rs = '0; register_rt = '0;
        sign_extend = '0; alusrc = 0; branch = 0; regdst = 0; link = 0; pc4 = '0;
        wreg_rd = '0; wreg_rt = '0;
        h_reset = 1'b1; h_in_valid = 1'b0; h_op = '0; h_rs = '0; h_rt = '0; h_se = '0; h_pc4 = '0;
        m_hi = '0; m_lo = '0;

        repeat (3) @(posedge clock);
        #1;
        check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_alu_result", {32'd0, alu_result}, 64'd0);
        check_val("rst_branch_addr", {32'd0, branch_addr}, 64'd0);
        check_val("rst_flags", {62'd0, do_branch, reg_write}, 64'd0);
        check_val("rst_wreg", {59'd0, wreg_address}, 64'd0);
        // reset outranks an offered operation
        in_valid = 1'b1; op = 4'd0; register_rs = 32'd1; register_rt = 32'd2;
        @(posedge clock); #1;
        check_val("rst_priority", {63'd0, out_valid}, 64'd0);
        @(negedge clock);
        in_valid = 1'b0;
        reset = 1'b0;
        h_reset = 1'b0;

        // directed cases
        run_op(4'd0, 32'd5, 32'd7, 32'd0, 0, 0, 1, 0, 32'h10, 5'd3, 5'd4);
        run_op(4'd1, 32'd9, 32'd9, 32'hFFFF_FFFE, 0, 1, 0, 0, 32'h100, 5'd3, 5'd4);
        run_op(4'd4, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 1, 0, 32'h0, 5'd5, 5'd6);
        run_op(4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 0, 0, 1, 0, 32'h0, 5'd5, 5'd6);
        run_op(4'd6, 32'd0, 32'd0, 32'h1234, 1, 0, 0, 0, 32'h0, 5'd5, 5'd6);
        run_op(4'd7, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 32'h40, 5'd5, 5'd6);
        idle_cycle();
        run_op(4'd8, 32'hFFFF_FFFF, 32'd2, 32'd0, 0, 0, 1, 0, 32'h0, 5'd7, 5'd8);
        run_op(4'd10, 32'd0, 32'd0, 32'd0, 0, 0, 1, 0, 32'h0, 5'd7, 5'd8);
        run_op(4'd11, 32'd0, 32'd0, 32'd0, 0, 0, 1, 0, 32'h0, 5'd7, 5'd8);
        run_op(4'd9, 32'd100, 32'd7, 32'd0, 0, 0, 1, 0, 32'h0, 5'd7, 5'd8);
        run_op(4'd10, 32'd0, 32'd0, 32'd0, 0, 0, 1, 0, 32'h0, 5'd7, 5'd8);
        run_op(4'd9, 32'd55, 32'd0, 32'd0, 0, 0, 1, 0, 32'h0, 5'd7, 5'd8);
        run_op(4'd10, 32'd0, 32'd0, 32'd0, 0, 0, 1, 0, 32'h0, 5'd7, 5'd8);
        run_op(4'd11, 32'd0, 32'd0, 32'd0, 0, 0, 1, 0, 32'h0, 5'd7, 5'd8);
        run_op(4'd13, 32'd3, 32'd4, 32'd0, 0, 0, 1, 0, 32'h0, 5'd7, 5'd8);
        idle_cycle();

        // randomized back-to-back traffic
        for (int i = 0; i < 150; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
            run_op(4'($urandom_range(0, 15)), ra, rb, $urandom, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), $urandom, 5'($urandom), 5'($urandom));
            if ($urandom_range(0, 7) == 0) idle_cycle();
        end

        // reset in the middle of a multiply
        @(negedge clock);
        op = 4'd8; register_rs = 32'd12345; register_rt = 32'd678; alusrc = 0; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        check_val("midrst_in_ready", {63'd0, in_ready}, 64'd1);
        check_val("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("midrst_alu_result", {32'd0, alu_result}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        m_hi = '0;
        m_lo = '0;
        pulses = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (out_valid) pulses++;
        end
        check_val("midrst_no_pulse", 64'(pulses), 64'd0);
        run_op(4'd10, 32'd0, 32'd0, 32'd0, 0, 0, 1, 0, 32'h0, 5'd1, 5'd2);
        run_op(4'd11, 32'd0, 32'd0, 32'd0, 0, 0, 1, 0, 32'h0, 5'd1, 5'd2);

        // 16-bit instance: ADD 5+7
        @(negedge clock);
        check_val("w16_in_ready", {63'd0, h_in_ready}, 64'd1);
        h_op = 4'd0; h_rs = 16'd5; h_rt = 16'd7; h_se = 16'd0; h_pc4 = 16'h20; h_in_valid = 1'b1;
        @(posedge clock); #1;
        h_in_valid = 1'b0;
        check_val("w16_out_valid", {63'd0, h_out_valid}, 64'd1);
        check_val("w16_alu_result", {48'd0, h_alu_result}, 64'd12);
        check_val("w16_flags", {62'd0, h_reg_write, h_do_branch}, 64'd2);
        check_val("w16_wreg", {59'd0, h_wreg_address}, 64'd3);
        check_val("w16_branch_addr", {48'd0, h_branch_addr}, 64'h20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
